// File: rtl/layer4_buf_ctrl.sv
// rtl/layer4_buf_ctrl.sv - layer4 SRAM fill/readback controller (port A writes, port B reads)
module layer4_buf_ctrl #(
  parameter int DEPTH = 144,
  parameter int AW    = 8
) (
  input  logic          CK,
  input  logic          RSTN,
  input  logic          clear,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [127:0]  wr_data,
  input  logic          rd_req,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [127:0]  rd_data,
  output logic          full,
  output logic [AW-1:0] wr_count,
  output logic          OEA,
  output logic          OEB,
  output logic          WEAN,
  output logic          WEBN,
  output logic [AW-1:0] A,
  output logic [AW-1:0] B,
  output logic [127:0]  DIA,
  output logic [127:0]  DIB,
  input  logic [127:0]  DOA,
  input  logic [127:0]  DOB
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL} state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t state;
  logic   wr_accept;
  logic   rd_accept;
  logic   unused_doa;

  // Handshakes; gated by RSTN so nothing is accepted while reset is held.
  // A read is only allowed below the write pointer, which also keeps A != B.
  always_comb begin
    wr_ready  = RSTN && !clear && (state != ST_FULL);
    wr_accept = wr_valid && wr_ready;
    rd_ready  = RSTN && !clear
                && ({1'b0, rd_addr} < {1'b0, wr_count})
                && ({1'b0, rd_addr} < DEPTH_EXT);
    rd_accept = rd_req && rd_ready;
  end

  // SRAM pin drive: port A write-only, port B read-only.
  always_comb begin
    WEAN    = !wr_accept;
    A       = wr_count;
    DIA     = wr_data;
    OEA     = 1'b0;
    WEBN    = 1'b1;
    DIB     = '0;
    OEB     = rd_accept;
    B       = rd_addr;
    rd_data = rd_valid ? DOB : '0;
  end

  // Port A read data has no consumer; reduce it so it is visibly consumed.
  assign unused_doa = ^DOA;

  // Fill state machine, write pointer and one-cycle read-valid pipeline.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_EMPTY;
      wr_count <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
    end else begin
      // A read accepted before clear still returns its data.
      rd_valid <= rd_accept;
      if (clear) begin
        state    <= ST_EMPTY;
        wr_count <= '0;
        full     <= 1'b0;
      end else if (wr_accept) begin
        wr_count <= wr_count + 1'b1;
        if (wr_count == LAST_IDX) begin
          state <= ST_FULL;
          full  <= 1'b1;
        end else begin
          state <= ST_FILL;
        end
      end
    end
  end

endmodule

// File: doc/layer4_buf_ctrl.md
LAYER4_BUF_CTRL -- requirements
Module: layer4_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 144, meaning number of 128-bit words in the layer4 SRAM.
REQ-002 SHALL have parameter AW, default 8, meaning SRAM address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, named CK and RSTN.
REQ-004 SHALL provide these ports, one per line:
- CK  in  1  clock; both SRAM ports share it.
- RSTN  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart of the fill sequence.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  controller accepts wr_data this cycle.
- wr_data  in  128  word to store.
- rd_req  in  1  consumer requests the word at rd_addr.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  AW  word index to read.
- rd_valid  out  1  rd_data valid.
- rd_data  out  128  read word.
- full  out  1  all DEPTH words written.
- wr_count  out  AW  number of words written since reset or clear.
- OEA, OEB  out  1 each  SRAM output enables.
- WEAN, WEBN  out  1 each  SRAM write enables, active low.
- A, B  out  AW each  SRAM port addresses.
- DIA, DIB  out  128 each  SRAM write data.
- DOA, DOB  in  128 each  SRAM read data.

Function
REQ-005 SHALL use port A as write-only: OEA=0 and WEBN=1 permanently, DIB=0 permanently.
REQ-006 SHALL use port B as read-only.
REQ-007 SHALL implement the state machine EMPTY -> FILL -> FULL.
REQ-008 SHALL move EMPTY->FILL on the first accepted write.
REQ-009 SHALL move FILL->FULL on the accepted write with wr_count == DEPTH-1.
REQ-010 SHALL move any state -> EMPTY on clear.
REQ-011 SHALL drive wr_ready = 1 in EMPTY/FILL and clear = 0; otherwise wr_ready = 0.
REQ-012 SHALL treat a write as accepted when wr_valid and wr_ready are both 1.
REQ-013 SHALL, in an accept cycle, combinationally drive WEAN=0, A=wr_count and DIA=wr_data; otherwise WEAN=1.
REQ-014 SHALL increment wr_count by 1 at the clock edge ending each accepted write.
REQ-015 SHALL hold wr_count at DEPTH in FULL, never wrap it, and ignore writes offered while full.
REQ-016 SHALL drive rd_ready = 1 only when rd_addr < wr_count and clear = 0, so only already-written words are readable.
REQ-017 SHALL treat a read as accepted when rd_req and rd_ready are both 1.
REQ-018 SHALL, in a read-accept cycle, combinationally drive OEB=1 and B=rd_addr; otherwise OEB=0.
REQ-019 SHALL drive B = rd_addr in every cycle.
REQ-020 SHALL assert rd_valid exactly one cycle after an accepted read; read latency is 1 cycle.
REQ-021 SHALL make rd_data = DOB while rd_valid = 1 and rd_data = 0 otherwise.
REQ-022 SHALL sustain back-to-back reads at one per cycle.
REQ-023 SHALL never present A == B with OEB = 1 or WEAN = 0 on both ports; the controller guarantees this by construction (REQ-016: read addresses < write pointer).
REQ-024 SHALL allow a simultaneous accepted write and accepted read in the same cycle, each using its own port.
REQ-025 SHALL complete a read accepted before clear: rd_valid and data still appear in the next cycle.
REQ-026 SHALL drive full = 1 iff the state is FULL.
REQ-027 SHALL refuse rd_addr >= DEPTH (rd_ready = 0), including in FULL.

Reset
REQ-028 SHALL, on RSTN low, asynchronously set state = EMPTY, wr_count = 0, rd_valid = 0 and full = 0.
REQ-029 SHALL hold these outputs during reset: wr_ready = 0, rd_ready = 0, WEAN = 1, WEBN = 1, OEA = 0, OEB = 0.
REQ-030 SHALL preserve SRAM contents across reset; contents are not guaranteed valid after reset, so reads are gated by wr_count.
REQ-031 SHALL, when reset is asserted mid-fill, abort any pending write, leave no rd_valid pulse after reset release, and restart the fill from address 0.

Verification
REQ-032 SHALL pass the fill test: stream words 0..143 with wr_valid held high -> 144 WEAN pulses at A = 0..143, full = 1 after the 144th edge, wr_ready = 0 afterwards, wr_count = 144.
REQ-033 SHALL pass the readback test: after fill, read addresses 143 down to 0 back-to-back -> rd_valid high for 144 consecutive cycles, each word matching what was written, 1-cycle latency.
REQ-034 SHALL pass the hazard test: with wr_count = 5, a read of rd_addr = 5 -> rd_ready = 0 until the 6th write is accepted, then rd_ready = 1 and the correct word returns.
REQ-035 SHALL pass the concurrent test: write address 10 and read address 3 in the same cycle -> A = 10, B = 3, WEAN = 0, OEB = 1, A never equals B, both words correct.
REQ-036 SHALL pass the clear test: clear asserted after 50 writes, with a read in flight -> the in-flight rd_valid still occurs, wr_count = 0 next cycle, state EMPTY, and the next write goes to A = 0.
REQ-037 SHALL pass the reset test: RSTN pulsed low asynchronously mid-fill at wr_count = 77 -> all outputs take reset values without a clock edge, and after release the first write goes to A = 0.
